// File: rtl/clk_sel_pkg.sv
// Shared types and helpers for the clock-select sequencer.
package clk_sel_pkg;

  // Sequencer phases: waiting for a request, waiting for the mux to settle,
  // acknowledging the requester, and enforcing the dwell gap.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    ACK    = 2'd2,
    HOLD   = 2'd3
  } clk_sel_state_e;

  // Width of the shared settle/dwell down-counter; it must hold the larger load.
  function automatic int cnt_width(input int settle_cyc, input int min_dwell);
    int max_load;
    max_load = (settle_cyc > min_dwell) ? settle_cyc : min_dwell;
    return $clog2(max_load + 1);
  endfunction

endpackage

// File: rtl/clk_sel_rr_arb.sv
// Combinational round-robin arbiter: searches from ptr+1 upward (wrapping)
// and returns the first active request as both an index and a one-hot vector.
module clk_sel_rr_arb #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               grant_valid,
  output logic [IDX_W-1:0]   grant_idx,
  output logic [NUM_REQ-1:0] grant_oh
);

  // Candidate index for each search offset (offset gi+1 from the pointer).
  logic [IDX_W-1:0]   cand_idx [NUM_REQ];
  logic [NUM_REQ-1:0] req_rot;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_cand
      // ptr < NUM_REQ and gi+1 <= NUM_REQ, so one conditional subtract wraps.
      logic [IDX_W:0] cand_sum;
      assign cand_sum      = {1'b0, ptr} + (IDX_W+1)'(gi + 1);
      assign cand_idx[gi]  = (cand_sum >= (IDX_W+1)'(NUM_REQ))
                             ? IDX_W'(cand_sum - (IDX_W+1)'(NUM_REQ))
                             : IDX_W'(cand_sum);
      assign req_rot[gi]   = req[cand_idx[gi]];
    end
  endgenerate

  // Priority pick over the rotated requests: the lowest offset wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        grant_valid = 1'b1;
        grant_idx   = cand_idx[k];
      end
    end
  end

  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_oh
      assign grant_oh[gi] = grant_valid && (grant_idx == IDX_W'(gi));
    end
  endgenerate

endmodule

// File: rtl/clk_sel_ctrl.sv
// Sequencer/arbiter for the 4:1 glitch-free clock mux: grants one select
// change at a time, waits for the mux synchronisers to settle, acknowledges
// the requester, then enforces a minimum dwell before the next grant.
module clk_sel_ctrl
  import clk_sel_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int NUM_CLK    = 4,
  parameter int SETTLE_CYC = 16,
  parameter int MIN_DWELL  = 8,
  parameter int RST_SEL    = 0,
  parameter int SEL_W      = $clog2(NUM_CLK),
  parameter int IDX_W      = $clog2(NUM_REQ)
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [NUM_REQ-1:0]       i_req,
  input  logic [NUM_REQ*SEL_W-1:0] i_req_sel,
  output logic [NUM_REQ-1:0]       o_ack,
  output logic [SEL_W-1:0]         o_sel,
  output logic                     o_busy,
  output logic [IDX_W-1:0]         o_owner
);

  localparam int CNT_W = cnt_width(SETTLE_CYC, MIN_DWELL);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] DWELL_LOAD  = CNT_W'((MIN_DWELL > 0) ? MIN_DWELL - 1 : 0);
  localparam bit               SEL_POW2    = ((1 << SEL_W) == NUM_CLK);

  // Parameter sanity checks at elaboration.
  generate
    if (SETTLE_CYC < 1) begin : g_bad_settle
      $error("clk_sel_ctrl: SETTLE_CYC must be >= 1");
    end
    if (RST_SEL >= NUM_CLK || RST_SEL < 0) begin : g_bad_rst_sel
      $error("clk_sel_ctrl: RST_SEL must be below NUM_CLK");
    end
    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
      $error("clk_sel_ctrl: NUM_REQ must be in 2..8");
    end
    if (NUM_CLK < 2) begin : g_bad_num_clk
      $error("clk_sel_ctrl: NUM_CLK must be >= 2");
    end
    if (MIN_DWELL < 0) begin : g_bad_dwell
      $error("clk_sel_ctrl: MIN_DWELL must be >= 0");
    end
  endgenerate

  clk_sel_state_e     state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [SEL_W-1:0]   sel_reg, sel_next;
  logic [NUM_REQ-1:0] ack_reg, ack_next;
  logic               busy_reg;
  logic [IDX_W-1:0]   owner_reg, owner_next;
  logic [IDX_W-1:0]   ptr_reg, ptr_next;

  logic               grant_valid;
  logic [IDX_W-1:0]   grant_idx;
  logic [NUM_REQ-1:0] grant_oh;
  logic [SEL_W-1:0]   req_tgt;
  logic               tgt_in_range;
  logic               need_switch;

  clk_sel_rr_arb #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req         (i_req),
    .ptr         (ptr_reg),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx),
    .grant_oh    (grant_oh)
  );

  // Winner's requested select; codes beyond the last mux input are treated
  // as "no change" so the requester is still acknowledged.
  assign req_tgt      = i_req_sel[grant_idx*SEL_W +: SEL_W];
  assign tgt_in_range = SEL_POW2 || ({1'b0, req_tgt} < (SEL_W+1)'(NUM_CLK));
  assign need_switch  = tgt_in_range && (req_tgt != sel_reg);

  // Next-state, counter, select and acknowledge logic.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    sel_next   = sel_reg;
    ack_next   = '0;
    owner_next = owner_reg;
    ptr_next   = ptr_reg;
    unique case (state_reg)
      IDLE: begin
        if (grant_valid) begin
          owner_next = grant_idx;
          ptr_next   = grant_idx;
          if (need_switch) begin
            sel_next   = req_tgt;
            cnt_next   = SETTLE_LOAD;
            state_next = SETTLE;
          end else begin
            ack_next   = grant_oh;
            state_next = ACK;
          end
        end
      end
      SETTLE: begin
        if (cnt_reg == '0) begin
          ack_next[owner_reg] = 1'b1;
          state_next          = ACK;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      ACK: begin
        if (MIN_DWELL > 0) begin
          cnt_next   = DWELL_LOAD;
          state_next = HOLD;
        end else begin
          state_next = IDLE;
        end
      end
      HOLD: begin
        if (cnt_reg == '0) begin
          state_next = IDLE;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State and output registers; reset aborts any switch in flight.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      sel_reg   <= SEL_W'(RST_SEL);
      ack_reg   <= '0;
      busy_reg  <= 1'b0;
      owner_reg <= '0;
      ptr_reg   <= IDX_W'(NUM_REQ - 1);
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      sel_reg   <= sel_next;
      ack_reg   <= ack_next;
      busy_reg  <= (state_next != IDLE);
      owner_reg <= owner_next;
      ptr_reg   <= ptr_next;
    end
  end

  assign o_ack   = ack_reg;
  assign o_sel   = sel_reg;
  assign o_busy  = busy_reg;
  assign o_owner = owner_reg;

endmodule
